// File: rtl/adc_spi_sampler.sv
// SPI master for an 8-channel 12-bit ADC: periodic 16-SCLK frames, tracking the
// one-frame address-to-data pipeline and tagging each returned sample with its channel.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  channel_addr,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_channel,
    output logic        sample_valid,
    output logic        busy
);

    localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TM_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT} state_t;

    state_t          state, state_d;
    logic [PH_W-1:0] ph, ph_d;
    logic [TM_W-1:0] timer, timer_d;
    logic [3:0]      bit_cnt, bit_cnt_d;
    logic            last_bit, last_bit_d;
    logic [15:0]     tx, tx_d;
    logic [11:0]     rx, rx_d;
    logic [2:0]      cur_ch, cur_ch_d;
    logic [2:0]      prev_ch, prev_ch_d;
    logic            first_frame, first_frame_d;
    logic            cs_n_d, sclk_d, mosi_d, busy_d, valid_d;
    logic [11:0]     data_d;
    logic [2:0]      chan_d;
    logic            start;
    logic [15:0]     tx_new;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            ph             <= '0;
            timer          <= '0;
            bit_cnt        <= '0;
            last_bit       <= 1'b0;
            tx             <= '0;
            rx             <= '0;
            cur_ch         <= '0;
            prev_ch        <= '0;
            first_frame    <= 1'b1;
            spi_cs_n       <= 1'b1;
            spi_sclk       <= 1'b1;
            spi_mosi       <= 1'b0;
            busy           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
            sample_channel <= '0;
        end else begin
            state          <= state_d;
            ph             <= ph_d;
            timer          <= timer_d;
            bit_cnt        <= bit_cnt_d;
            last_bit       <= last_bit_d;
            tx             <= tx_d;
            rx             <= rx_d;
            cur_ch         <= cur_ch_d;
            prev_ch        <= prev_ch_d;
            first_frame    <= first_frame_d;
            spi_cs_n       <= cs_n_d;
            spi_sclk       <= sclk_d;
            spi_mosi       <= mosi_d;
            busy           <= busy_d;
            sample_valid   <= valid_d;
            sample_data    <= data_d;
            sample_channel <= chan_d;
        end
    end

    always_comb begin
        state_d       = state;
        ph_d          = ph;
        timer_d       = (timer != TM_LAST) ? timer + 1'b1 : timer;
        bit_cnt_d     = bit_cnt;
        last_bit_d    = last_bit;
        tx_d          = tx;
        rx_d          = rx;
        cur_ch_d      = cur_ch;
        prev_ch_d     = prev_ch;
        first_frame_d = first_frame;
        cs_n_d        = spi_cs_n;
        sclk_d        = spi_sclk;
        mosi_d        = spi_mosi;
        busy_d        = busy;
        valid_d       = 1'b0;
        data_d        = sample_data;
        chan_d        = sample_channel;
        start         = 1'b0;
        tx_new        = {2'b00, channel_addr, 11'b0};

        case (state)
            IDLE: begin
                timer_d = '0;
                if (enable) start = 1'b1;
            end
            SETUP: begin
                if (ph == PH_LAST) begin
                    ph_d       = '0;
                    sclk_d     = 1'b0;
                    mosi_d     = tx[15];
                    bit_cnt_d  = '0;
                    last_bit_d = 1'b0;
                    state_d    = SHIFT;
                end else begin
                    ph_d = ph + 1'b1;
                end
            end
            SHIFT: begin
                if (ph != PH_LAST) begin
                    ph_d = ph + 1'b1;
                end else begin
                    ph_d = '0;
                    if (!spi_sclk) begin
                        // Only the low 12 bits are kept; the ADC's leading zeros fall off the top.
                        sclk_d = 1'b1;
                        rx_d   = {rx[10:0], spi_miso};
                    end else if (last_bit) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d     = 1'b0;
                        mosi_d     = tx[14];
                        tx_d       = {tx[14:0], 1'b0};
                        bit_cnt_d  = bit_cnt + 4'd1;
                        last_bit_d = (bit_cnt == 4'd14);
                    end
                end
            end
            HOLD: begin
                if (ph == PH_LAST) begin
                    ph_d          = '0;
                    cs_n_d        = 1'b1;
                    busy_d        = 1'b0;
                    mosi_d        = 1'b0;
                    // This frame's data belongs to the channel addressed in the previous frame.
                    if (!first_frame) begin
                        valid_d = 1'b1;
                        data_d  = rx;
                        chan_d  = prev_ch;
                    end
                    prev_ch_d     = cur_ch;
                    first_frame_d = 1'b0;
                    state_d       = WAIT;
                end else begin
                    ph_d = ph + 1'b1;
                end
            end
            WAIT: begin
                if (timer == TM_LAST) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            cur_ch_d = channel_addr;
            tx_d     = tx_new;
            mosi_d   = tx_new[15];
            cs_n_d   = 1'b0;
            sclk_d   = 1'b1;
            busy_d   = 1'b1;
            timer_d  = '0;
            ph_d     = '0;
            state_d  = SETUP;
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler with a behavioural ADC that answers for the
// channel addressed in the previous complete frame.
module tb_adc_spi_sampler;

    logic        clk;
    logic        resetn;
    logic [2:0]  channel_addr;
    logic        enable;
    logic        spi_miso;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        sample_valid;
    logic        busy;

    adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_DIV(100)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .channel_addr   (channel_addr),
        .enable         (enable),
        .spi_miso       (spi_miso),
        .spi_cs_n       (spi_cs_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [8];
    logic [14:0] sb [$];

    int          cyc = 0;
    int          falls = 0;
    int          rises = 0;
    int          last_fall = 0;
    int          prev_fall = 0;
    int          cs_cnt = 0;
    int          last_len = 0;
    int          valid_count = 0;
    logic [15:0] mw = '0;
    int          mb = 0;
    logic [15:0] last_mosi = '0;
    int          last_bits = 0;
    logic        m_cs = 1'b1;
    logic        m_sclk = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input string name);
        int start_n;
        int n;
        start_n = falls;
        n = 0;
        while (falls == start_n && n < 400) begin
            tick();
            n++;
        end
        if (falls == start_n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for CS fall", name);
        end
    endtask

    task automatic wait_rise(input string name);
        int start_n;
        int n;
        start_n = rises;
        n = 0;
        while (rises == start_n && n < 400) begin
            tick();
            n++;
        end
        if (rises == start_n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for CS rise", name);
        end
    endtask

    // ADC model: shifts out on SCLK falls, samples MOSI on SCLK rises,
    // and only adopts a new address after a complete 16-bit frame.
    logic [2:0]  adc_addr = 3'd0;
    logic [15:0] adc_out = '0;
    logic [15:0] adc_in = '0;
    int          adc_bits = 0;
    logic        a_cs = 1'b1;
    logic        a_sclk = 1'b1;

    initial begin
        spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (a_cs === 1'b1 && spi_cs_n === 1'b0) begin
                adc_out  = {4'b0, mem[adc_addr]};
                adc_in   = '0;
                adc_bits = 0;
            end
            if (spi_cs_n === 1'b0 && a_sclk === 1'b1 && spi_sclk === 1'b0) begin
                spi_miso = adc_out[15];
                adc_out  = {adc_out[14:0], 1'b0};
            end
            if (a_cs === 1'b0 && a_sclk === 1'b0 && spi_sclk === 1'b1) begin
                adc_in = {adc_in[14:0], spi_mosi};
                adc_bits++;
            end
            if (a_cs === 1'b0 && spi_cs_n === 1'b1 && adc_bits == 16)
                adc_addr = adc_in[13:11];
            a_cs   = spi_cs_n;
            a_sclk = spi_sclk;
        end
    end

    initial begin
        logic [14:0] exp_item;
        forever begin
            @(negedge clk);
            if (m_cs === 1'b1 && spi_cs_n === 1'b0) begin
                prev_fall = last_fall;
                last_fall = cyc;
                falls++;
                cs_cnt = 0;
                mw = '0;
                mb = 0;
            end
            if (spi_cs_n === 1'b0) cs_cnt++;
            if (spi_cs_n === 1'b0 && m_sclk === 1'b1 && spi_sclk === 1'b0) begin
                mw = {mw[14:0], spi_mosi};
                mb++;
            end
            if (m_cs === 1'b0 && spi_cs_n === 1'b1) begin
                rises++;
                last_len  = cs_cnt;
                last_mosi = mw;
                last_bits = mb;
            end
            if (sample_valid === 1'b1) begin
                valid_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual ch=%0d data=%0h required no valid",
                             sample_channel, sample_data);
                end else begin
                    exp_item = sb.pop_front();
                    chk("valid_channel", 32'(sample_channel), 32'(exp_item[14:12]));
                    chk("valid_data", 32'(sample_data), 32'(exp_item[11:0]));
                end
            end
            m_cs   = spi_cs_n;
            m_sclk = spi_sclk;
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f_before;
        int vc_before;
        mem[0] = 12'h5A0; mem[1] = 12'h0F1; mem[2] = 12'h123; mem[3] = 12'h8E3;
        mem[4] = 12'h444; mem[5] = 12'hABC; mem[6] = 12'hFFF; mem[7] = 12'h7C7;

        resetn = 1'b0;
        enable = 1'b0;
        channel_addr = 3'd5;
        repeat (5) tick();
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd1);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_channel", 32'(sample_channel), 32'd0);

        sb.push_back({3'd5, 12'hABC});
        sb.push_back({3'd5, 12'hABC});
        sb.push_back({3'd2, 12'h123});
        resetn = 1'b1;
        enable = 1'b1;

        wait_fall("f1_start");
        chk("f1_busy", 32'(busy), 32'd1);
        wait_rise("f1_end");
        chk("f1_cs_len", 32'(last_len), 32'd68);
        chk("f1_mosi", 32'(last_mosi), 32'h2800);
        chk("f1_bits", 32'(last_bits), 32'd16);
        repeat (3) tick();
        chk("f1_no_valid", 32'(valid_count), 32'd0);

        wait_fall("f2_start");
        chk("f2_period", 32'(last_fall - prev_fall), 32'd100);
        repeat (20) tick();
        channel_addr = 3'd2;
        wait_rise("f2_end");
        chk("f2_mosi", 32'(last_mosi), 32'h2800);
        repeat (3) tick();
        chk("f2_valid_count", 32'(valid_count), 32'd1);

        wait_fall("f3_start");
        chk("f3_period", 32'(last_fall - prev_fall), 32'd100);
        wait_rise("f3_end");
        chk("f3_mosi", 32'(last_mosi), 32'h1000);
        repeat (3) tick();
        chk("f3_valid_count", 32'(valid_count), 32'd2);

        wait_fall("f4_start");
        repeat (20) tick();
        enable = 1'b0;
        wait_rise("f4_end");
        chk("f4_mosi", 32'(last_mosi), 32'h1000);
        repeat (3) tick();
        chk("f4_valid_count", 32'(valid_count), 32'd3);

        f_before = falls;
        repeat (320) tick();
        chk("idle_no_frames", 32'(falls), 32'(f_before));
        chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        sb.push_back({3'd2, 12'h123});
        channel_addr = 3'd3;
        enable = 1'b1;
        wait_fall("f5_start");
        wait_rise("f5_end");
        chk("f5_mosi", 32'(last_mosi), 32'h1800);
        repeat (3) tick();
        chk("f5_valid_count", 32'(valid_count), 32'd4);
        repeat (10) tick();
        chk("hold_data", 32'(sample_data), 32'h123);
        chk("hold_channel", 32'(sample_channel), 32'd2);

        wait_fall("f6_start");
        repeat (20) tick();
        resetn = 1'b0;
        tick();
        chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("midrst_sclk", 32'(spi_sclk), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(sample_data), 32'd0);
        repeat (3) tick();
        vc_before = valid_count;
        sb.push_back({3'd6, 12'hFFF});
        channel_addr = 3'd6;
        resetn = 1'b1;

        wait_fall("fa_start");
        wait_rise("fa_end");
        chk("fa_mosi", 32'(last_mosi), 32'h3000);
        repeat (3) tick();
        chk("fa_no_valid", 32'(valid_count), 32'(vc_before));

        wait_fall("fb_start");
        wait_rise("fb_end");
        repeat (3) tick();
        chk("fb_valid_count", 32'(valid_count), 32'(vc_before + 1));

        enable = 1'b0;
        repeat (5) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
